hex_display_sched: RTL

HEX_DISPLAY_SCHED -- requirements
Module: hex_display_sched

---
 rtl/hex_display_sched.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/hex_display_sched.sv
// rtl/hex_display_sched.sv - six-digit scanned hex display with BCD score counter
//
// hex_decoder: 4-bit value to active-low seven-segment pattern.
//   i_val  [3:0]  value to decode
//   o_seg  [6:0]  segments, bit0 = a .. bit6 = g, 0 = segment lit
//
// hex_display_sched: holds a four-digit BCD score (digits 3..0) and two
// general hex digits (5..4), and refreshes HEX0..HEX5 one slot at a time
// through a single shared decoder.
//   clock             rising-edge clock
//   reset             synchronous active-high reset
//   inc               add 1 to the score (dropped while busy or at 9999)
//   clr               clear the score; overrides inc and aborts a carry
//   wr_en/wr_addr/wr_data  write a general digit (only addresses 4 and 5)
//   busy              score carry sequence in progress
//   frame             one-cycle pulse after HEX5 has been refreshed
//   HEX0..HEX5        registered active-low segment drives

module hex_decoder (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_val)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

module hex_display_sched #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          LZB      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       busy,
  output logic       frame,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CARRY = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  // Score FSM
  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_k;
  logic [1:0]  w_k_nxt;
  logic [15:0] r_score;       // BCD, digit 0 in [3:0]
  logic [15:0] w_score_nxt;
  logic [3:0]  w_cur_digit;
  logic        w_score_max;

  // General digits
  logic [3:0]  r_dig4;
  logic [3:0]  r_dig5;

  // Scanner
  logic [7:0]  r_div;
  logic [2:0]  r_slot;
  logic        r_frame;
  logic [6:0]  r_hex [6];
  logic        w_div_last;
  logic [3:0]  w_slot_val;
  logic        w_slot_blank;
  logic [6:0]  w_seg;

  assign w_cur_digit = r_score[{r_k, 2'b00} +: 4];
  assign w_score_max = (r_score == 16'h9999);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_score_nxt = r_score;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_k_nxt     = 2'd0;
      w_score_nxt = 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inc && !w_score_max) begin
            w_state_nxt = S_CARRY;
            w_k_nxt     = 2'd0;
          end
        end
        S_CARRY: begin
          if (w_cur_digit == 4'd9) begin
            w_score_nxt[{r_k, 2'b00} +: 4] = 4'd0;
            // Saturation at 9999 keeps k from running past digit 3; the
            // guard only stops a wrap if that invariant were ever broken.
            if (r_k == 2'd3) begin
              w_state_nxt = S_IDLE;
              w_k_nxt     = 2'd0;
            end else begin
              w_k_nxt = r_k + 2'd1;
            end
          end else begin
            w_score_nxt[{r_k, 2'b00} +: 4] = w_cur_digit + 4'd1;
            w_state_nxt = S_IDLE;
            w_k_nxt     = 2'd0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_score <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_score <= w_score_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dig4 <= 4'd0;
      r_dig5 <= 4'd0;
    end else if (wr_en) begin
      if (wr_addr == 3'd4) r_dig4 <= wr_data;
      if (wr_addr == 3'd5) r_dig5 <= wr_data;
    end
  end

  assign w_div_last = (r_div == DIV_LAST);

  always_comb begin
    w_slot_val = 4'd0;
    case (r_slot)
      3'd0: w_slot_val = r_score[3:0];
      3'd1: w_slot_val = r_score[7:4];
      3'd2: w_slot_val = r_score[11:8];
      3'd3: w_slot_val = r_score[15:12];
      3'd4: w_slot_val = r_dig4;
      3'd5: w_slot_val = r_dig5;
      default: w_slot_val = 4'd0;
    endcase
  end

  // A score digit is blank when it and every score digit above it are zero.
  always_comb begin
    w_slot_blank = 1'b0;
    if (LZB) begin
      case (r_slot)
        3'd1: w_slot_blank = (r_score[15:4] == 12'h000);
        3'd2: w_slot_blank = (r_score[15:8] == 8'h00);
        3'd3: w_slot_blank = (r_score[15:12] == 4'h0);
        default: w_slot_blank = 1'b0;
      endcase
    end
  end

  hex_decoder u_dec (
    .i_val (w_slot_val),
    .o_seg (w_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div   <= 8'd0;
      r_slot  <= 3'd0;
      r_frame <= 1'b0;
      for (int i = 0; i < 6; i++) r_hex[i] <= 7'h7F;
    end else begin
      r_frame <= w_div_last && (r_slot == 3'd5);
      if (w_div_last) begin
        r_hex[r_slot] <= w_slot_blank ? 7'h7F : w_seg;
        r_slot        <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
        r_div         <= 8'd0;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign busy  = (r_state == S_CARRY);
  assign frame = r_frame;
  assign HEX0  = r_hex[0];
  assign HEX1  = r_hex[1];
  assign HEX2  = r_hex[2];
  assign HEX3  = r_hex[3];
  assign HEX4  = r_hex[4];
  assign HEX5  = r_hex[5];

endmodule
